// File: rtl/int_stim_pkg.sv
// ============================================================================
// Module      : int_stim_pkg
// Description : Shared types and constants for the interrupt stimulus block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package int_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DLY = 2'd1,
        ST_ASSERT   = 2'd2,
        ST_DONE     = 2'd3
    } chan_state_t;

    localparam int ACK_STRIDE = 4;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_PULSE = 1;

    // Word-granular address compare; the two byte-offset bits never matter.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return ((a & ~32'd3) == (b & ~32'd3));
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_stim_chan.sv
// ============================================================================
// Module      : int_stim_chan
// Description : One interrupt channel: trigger FSM with delay and pulse counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module int_stim_chan
    import int_stim_pkg::*;
#(
    parameter int          DLY_W      = 16,
    parameter int          PULSE_MODE = MODE_LEVEL,
    parameter int          PULSE_LEN  = 4,
    parameter logic [31:0] ACK_ADDR   = 32'h7f20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [31:0]      pc,
    input  logic [31:0]      trig_pc,
    input  logic [DLY_W-1:0] delay,
    input  logic [31:0]      store_addr,
    input  logic [3:0]       store_byteen,
    input  logic             budget_ok,
    input  logic             grant,
    output logic             req,
    output logic             irq
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    chan_state_t      state;
    chan_state_t      state_nxt;
    logic [DLY_W-1:0] dcnt;
    logic [DLY_W-1:0] dcnt_nxt;
    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_nxt;
    logic             pc_hit;
    logic             ack_hit;

    assign pc_hit  = word_match(pc, trig_pc);
    assign ack_hit = (|store_byteen) && word_match(store_addr, ACK_ADDR);

    // Request to enter ASSERT; the top level grants it against the budget.
    assign req = en && (state == ST_WAIT_DLY) && (dcnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            dcnt  <= '0;
            pcnt  <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            pcnt  <= pcnt_nxt;
            irq   <= (state_nxt == ST_ASSERT);
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        pcnt_nxt  = pcnt;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_hit && budget_ok) begin
                        state_nxt = ST_WAIT_DLY;
                        dcnt_nxt  = delay;
                    end
                end
                ST_WAIT_DLY: begin
                    if (dcnt == '0) begin
                        if (grant) begin
                            state_nxt = ST_ASSERT;
                            pcnt_nxt  = PW'(PULSE_LEN - 1);
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        dcnt_nxt = dcnt - DLY_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (PULSE_MODE == MODE_PULSE) begin
                        if (pcnt == '0) begin
                            state_nxt = ST_DONE;
                        end else begin
                            pcnt_nxt = pcnt - PW'(1);
                        end
                    end else if ((PULSE_MODE == MODE_LEVEL) && ack_hit) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!pc_hit) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_stimulus.sv
// ============================================================================
// Module      : int_stimulus
// Description : PC-triggered multi-channel interrupt generator with a global budget.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module int_stimulus
    import int_stim_pkg::*;
#(
    parameter int          NUM_CH      = 6,
    parameter int          DLY_W       = 16,
    parameter logic [31:0] ACK_BASE    = 32'h7f20,
    parameter int          PULSE_MODE  = MODE_LEVEL,
    parameter int          PULSE_LEN   = 4,
    parameter int          BUDGET_W    = 32,
    parameter int          BUDGET_INIT = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             macroscopic_pc,
    input  logic [31:0]             m_int_addr,
    input  logic [3:0]              m_int_byteen,
    input  logic [32*NUM_CH-1:0]    cfg_trig_pc,
    input  logic [DLY_W*NUM_CH-1:0] cfg_delay,
    input  logic [NUM_CH-1:0]       cfg_en,
    output logic [NUM_CH-1:0]       interrupt,
    output logic                    irq_any,
    output logic [BUDGET_W-1:0]     fired_cnt,
    output logic                    budget_empty
);

    logic [BUDGET_W-1:0] budget;
    logic [BUDGET_W-1:0] budget_left;
    logic [BUDGET_W:0]   fired_sum;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   grant;
    logic                budget_ok;

    assign budget_ok = (budget != '0);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            int_stim_chan #(
                .DLY_W      (DLY_W),
                .PULSE_MODE (PULSE_MODE),
                .PULSE_LEN  (PULSE_LEN),
                .ACK_ADDR   (ACK_BASE + 32'(ACK_STRIDE * k))
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .en           (cfg_en[k]),
                .pc           (macroscopic_pc),
                .trig_pc      (cfg_trig_pc[32*k +: 32]),
                .delay        (cfg_delay[DLY_W*k +: DLY_W]),
                .store_addr   (m_int_addr),
                .store_byteen (m_int_byteen),
                .budget_ok    (budget_ok),
                .grant        (grant[k]),
                .req          (req[k]),
                .irq          (interrupt[k])
            );
        end
    endgenerate

    // Lowest index wins while budget remains; refused channels fall back to IDLE.
    always_comb begin
        grant       = '0;
        budget_left = budget;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req[k] && (budget_left != '0)) begin
                grant[k]    = 1'b1;
                budget_left = budget_left - BUDGET_W'(1);
            end
        end
    end

    assign fired_sum = {1'b0, fired_cnt} + {1'b0, budget - budget_left};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            budget    <= BUDGET_W'(BUDGET_INIT);
            fired_cnt <= '0;
        end else begin
            budget    <= budget_left;
            fired_cnt <= fired_sum[BUDGET_W] ? '1 : fired_sum[BUDGET_W-1:0];
        end
    end

    assign irq_any      = |interrupt;
    assign budget_empty = (budget == '0);

endmodule

`default_nettype wire

// File: tb/tb_int_stimulus.sv
// ============================================================================
// Module      : tb_int_stimulus
// Description : Scoreboard bench for int_stimulus in level, budget-1 and pulse setups.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_int_stimulus;

    localparam int S_LVL_IRQ   = 0;
    localparam int S_LVL_ANY   = 1;
    localparam int S_LVL_FIRED = 2;
    localparam int S_BUD_IRQ   = 3;
    localparam int S_BUD_EMPTY = 4;
    localparam int S_BUD_FIRED = 5;
    localparam int S_PLS_IRQ   = 6;
    localparam int S_PLS_FIRED = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;

    logic [191:0] lvl_trig, bud_trig, pls_trig;
    logic [95:0]  lvl_dly, bud_dly, pls_dly;
    logic [5:0]   lvl_en, bud_en, pls_en;

    logic [5:0]  lvl_irq, bud_irq, pls_irq;
    logic        lvl_any, bud_any, pls_any;
    logic [31:0] lvl_fired, bud_fired, pls_fired;
    logic        lvl_empty, bud_empty, pls_empty;

    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    sb_item_t sb[$];

    int_stimulus u_lvl (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr),
        .m_int_byteen(byteen), .cfg_trig_pc(lvl_trig), .cfg_delay(lvl_dly),
        .cfg_en(lvl_en), .interrupt(lvl_irq), .irq_any(lvl_any),
        .fired_cnt(lvl_fired), .budget_empty(lvl_empty)
    );

    int_stimulus #(.BUDGET_INIT(1)) u_bud (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr),
        .m_int_byteen(byteen), .cfg_trig_pc(bud_trig), .cfg_delay(bud_dly),
        .cfg_en(bud_en), .interrupt(bud_irq), .irq_any(bud_any),
        .fired_cnt(bud_fired), .budget_empty(bud_empty)
    );

    int_stimulus #(.PULSE_MODE(1), .PULSE_LEN(4)) u_pls (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_int_addr(addr),
        .m_int_byteen(byteen), .cfg_trig_pc(pls_trig), .cfg_delay(pls_dly),
        .cfg_en(pls_en), .interrupt(pls_irq), .irq_any(pls_any),
        .fired_cnt(pls_fired), .budget_empty(pls_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_LVL_IRQ:   return 32'(lvl_irq);
            S_LVL_ANY:   return 32'(lvl_any);
            S_LVL_FIRED: return lvl_fired;
            S_BUD_IRQ:   return 32'(bud_irq);
            S_BUD_EMPTY: return 32'(bud_empty);
            S_BUD_FIRED: return bud_fired;
            S_PLS_IRQ:   return 32'(pls_irq);
            S_PLS_FIRED: return pls_fired;
            default:     return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_at(input int sig, input int off, input logic [31:0] v, input string tag);
        sb.push_back('{cyc + off, sig, v, tag});
    endtask

    // Scoreboard drain: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_val(sb[i].tag, observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        pc     = '0;
        addr   = '0;
        byteen = '0;
        #2;
        check_val("rst_lvl_irq",   32'(lvl_irq),   32'h0);
        check_val("rst_lvl_any",   32'(lvl_any),   32'h0);
        check_val("rst_lvl_fired", lvl_fired,      32'h0);
        check_val("rst_lvl_empty", 32'(lvl_empty), 32'h0);
        check_val("rst_bud_irq",   32'(bud_irq),   32'h0);
        check_val("rst_bud_empty", 32'(bud_empty), 32'h0);
        check_val("rst_bud_fired", bud_fired,      32'h0);
        check_val("rst_pls_irq",   32'(pls_irq),   32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lvl_trig = '0; bud_trig = '0; pls_trig = '0;
        lvl_dly  = '0; bud_dly  = '0; pls_dly  = '0;
        lvl_trig[0 +: 32]  = 32'h3010; lvl_dly[0 +: 16]  = 16'd3;
        lvl_trig[32 +: 32] = 32'h3020; lvl_dly[16 +: 16] = 16'd0;
        lvl_en = 6'b000011;
        bud_trig[32 +: 32] = 32'h4000; bud_dly[16 +: 16] = 16'd1;
        bud_trig[96 +: 32] = 32'h4003; bud_dly[48 +: 16] = 16'd1;
        bud_en = 6'b001010;
        pls_trig[0 +: 32]  = 32'h5000; pls_dly[0 +: 16]  = 16'd0;
        pls_en = 6'b000001;
        tick();

        // Basic level-mode fire and acknowledge, delay 3.
        do_reset();
        pc = 32'h3010;
        expect_at(S_LVL_IRQ,   4, 32'h0, "a_irq_wait");
        expect_at(S_LVL_IRQ,   5, 32'h1, "a_irq_rise");
        expect_at(S_LVL_ANY,   5, 32'h1, "a_any");
        expect_at(S_LVL_FIRED, 5, 32'h1, "a_fired");
        expect_at(S_LVL_IRQ,   6, 32'h1, "a_irq_hold");
        expect_at(S_LVL_IRQ,   7, 32'h0, "a_irq_ack");
        expect_at(S_LVL_FIRED, 7, 32'h1, "a_fired_after");
        tick(); pc = '0;
        repeat (5) tick();
        addr = 32'h7f20; byteen = 4'b0001;
        tick(); byteen = '0;
        repeat (4) tick();

        // PC parked on the trigger with acks: one fire per visit.
        do_reset();
        pc = 32'h3010;
        expect_at(S_LVL_IRQ, 4, 32'h0, "b_pre");
        expect_at(S_LVL_IRQ, 5, 32'h1, "b_rise");
        for (int k = 6; k <= 20; k++) expect_at(S_LVL_IRQ, k, 32'h0, "b_once");
        expect_at(S_LVL_FIRED, 19, 32'h1, "b_fired1");
        expect_at(S_LVL_IRQ,   25, 32'h0, "b_pre2");
        expect_at(S_LVL_IRQ,   26, 32'h1, "b_rerise");
        expect_at(S_LVL_FIRED, 26, 32'h2, "b_fired2");
        tick(); tick();
        addr = 32'h7f20; byteen = 4'b0001;
        repeat (18) tick();
        pc = '0; byteen = '0;
        tick(); pc = 32'h3010;
        repeat (6) tick();
        pc = '0; addr = 32'h7f20; byteen = 4'b0001;
        tick(); byteen = '0;
        repeat (3) tick();

        // Ack to the neighbour's word is ignored; any byte of own word clears.
        do_reset();
        pc = 32'h3010;
        expect_at(S_LVL_IRQ,   5, 32'h1, "c_rise");
        expect_at(S_LVL_IRQ,   6, 32'h1, "c_other_ack");
        expect_at(S_LVL_IRQ,   7, 32'h1, "c_other_ack2");
        expect_at(S_LVL_IRQ,   8, 32'h0, "c_byte_ack");
        expect_at(S_LVL_FIRED, 8, 32'h1, "c_fired");
        tick(); pc = '0;
        repeat (4) tick();
        addr = 32'h7f24; byteen = 4'b0001;
        repeat (2) tick();
        addr = 32'h7f23; byteen = 4'b1000;
        tick(); byteen = '0;
        repeat (2) tick();

        // Reset in WAIT_DLY with counter at 2.
        pc = 32'h3010;
        tick(); pc = '0;
        tick();
        reset = 1'b0;
        #2;
        check_val("f_rst_irq",   32'(lvl_irq),   32'h0);
        check_val("f_rst_fired", lvl_fired,      32'h0);
        check_val("f_rst_empty", 32'(lvl_empty), 32'h0);
        tick(); tick();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) expect_at(S_LVL_IRQ, k, 32'h0, "f_no_irq");
        expect_at(S_LVL_FIRED, 8, 32'h0, "f_fired");
        repeat (10) tick();

        // Zero delay: interrupt one cycle after the match.
        do_reset();
        pc = 32'h3020;
        expect_at(S_LVL_IRQ, 1, 32'h0, "g_d0_wait");
        expect_at(S_LVL_IRQ, 2, 32'h2, "g_d0_rise");
        expect_at(S_LVL_IRQ, 3, 32'h0, "g_d0_clr");
        tick(); pc = '0;
        tick();
        addr = 32'h7f24; byteen = 4'b0010;
        tick(); byteen = '0;
        repeat (3) tick();

        // Budget of one with a simultaneous ch1/ch3 request.
        do_reset();
        pc = 32'h4000;
        expect_at(S_BUD_IRQ,    2, 32'h0, "d_wait");
        expect_at(S_BUD_EMPTY,  2, 32'h0, "d_empty_pre");
        expect_at(S_BUD_IRQ,    3, 32'h2, "d_lowest_wins");
        expect_at(S_BUD_EMPTY,  3, 32'h1, "d_empty");
        expect_at(S_BUD_FIRED,  3, 32'h1, "d_fired");
        expect_at(S_BUD_IRQ,    8, 32'h2, "d_hold");
        expect_at(S_BUD_IRQ,   10, 32'h0, "d_ack");
        expect_at(S_BUD_IRQ,   20, 32'h0, "d_ignored");
        expect_at(S_BUD_FIRED, 20, 32'h1, "d_fired_final");
        expect_at(S_BUD_EMPTY, 20, 32'h1, "d_empty_final");
        repeat (9) tick();
        addr = 32'h7f24; byteen = 4'b0001;
        tick(); byteen = '0;
        tick(); pc = '0;
        tick(); pc = 32'h4000;
        repeat (10) tick();
        pc = '0;
        repeat (2) tick();

        // Pulse mode: four cycles high, mid-pulse ack ignored.
        do_reset();
        pc = 32'h5000;
        expect_at(S_PLS_IRQ, 1, 32'h0, "e_pre");
        for (int k = 2; k <= 5; k++) expect_at(S_PLS_IRQ, k, 32'h1, "e_pulse");
        expect_at(S_PLS_IRQ,    6, 32'h0, "e_end");
        expect_at(S_PLS_FIRED,  6, 32'h1, "e_fired");
        expect_at(S_PLS_IRQ,   10, 32'h0, "e_stays_low");
        tick(); pc = '0;
        tick(); tick();
        addr = 32'h7f20; byteen = 4'b0001;
        tick(); byteen = '0;
        repeat (10) tick();

        check_val("sb_drain", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_stimulus.md
INT_STIMULUS -- requirements
Module: int_stimulus

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, giving the number of independent interrupt channels (1..8).
REQ-002 SHALL have parameter DLY_W, default 16, giving the per-channel delay counter width.
REQ-003 SHALL have parameter ACK_BASE, default 32'h7f20, giving the acknowledge address of channel 0; channel k acknowledges at ACK_BASE+4k.
REQ-004 SHALL have parameter PULSE_MODE, default 0; 0 means level (held until ack), 1 means pulse (held PULSE_LEN cycles, ack ignored).
REQ-005 SHALL have parameter PULSE_LEN, default 4, giving the pulse width in cycles (>=1).
REQ-006 SHALL have parameter BUDGET_W, default 32, and BUDGET_INIT, default 100, giving the total-interrupt budget.
REQ-007 SHALL have ports: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-008 SHALL have ports: macroscopic_pc input 32 (committed PC; bits [1:0] ignored); m_int_addr input 32 (store address); m_int_byteen input 4 (store byte enables).
REQ-009 SHALL have ports: cfg_trig_pc input 32*NUM_CH (per-channel trigger PC, channel k at bits [32k+31:32k]); cfg_delay input DLY_W*NUM_CH (per-channel delay); cfg_en input NUM_CH (channel enable).
REQ-010 SHALL have ports: interrupt output NUM_CH (per-channel request); irq_any output 1 (OR of interrupt); fired_cnt output BUDGET_W (count of interrupts raised); budget_empty output 1.

Function
REQ-011 SHALL give each channel a 4-state FSM: IDLE, WAIT_DLY, ASSERT, DONE.
REQ-012 SHALL move IDLE->WAIT_DLY when cfg_en[k]=1, (macroscopic_pc & ~3)==(cfg_trig_pc[k] & ~3), and budget>0; the delay counter loads cfg_delay[k] on this transition.
REQ-013 SHALL decrement the counter once per cycle in WAIT_DLY, and move WAIT_DLY->ASSERT on the cycle after the counter reads 0; cfg_delay=0 therefore gives interrupt[k] high exactly 1 cycle after the PC match.
REQ-014 SHALL drive interrupt[k]=1 from a register only while the channel is in ASSERT; interrupt[k] SHALL have no combinational path from inputs.
REQ-015 SHALL, in level mode, move ASSERT->DONE on the first cycle with |m_int_byteen and (m_int_addr & ~3)==ACK_BASE+4k; interrupt[k] SHALL be low the following cycle.
REQ-016 SHALL, in pulse mode, move ASSERT->DONE after exactly PULSE_LEN cycles high, ignoring acknowledges.
REQ-017 SHALL move DONE->IDLE only once macroscopic_pc no longer matches cfg_trig_pc[k], so a single PC visit fires the channel once.
REQ-018 SHALL decrement the budget and increment fired_cnt by the number of channels entering ASSERT that cycle.
REQ-019 SHALL, when more channels request entry to ASSERT in one cycle than the budget allows, admit the lowest indices first; channels not admitted return to IDLE.
REQ-020 SHALL assert budget_empty while budget==0; in that state no channel leaves IDLE, while channels already in WAIT_DLY or ASSERT complete normally.
REQ-021 SHALL treat cfg_en[k] deasserting as a forced return to IDLE from any state (interrupt[k] low next cycle) without refunding the budget.
REQ-022 SHALL ignore an acknowledge received while a channel is not in ASSERT.
REQ-023 SHALL keep fired_cnt saturating at its all-ones value.

Reset
REQ-024 SHALL, while reset=0, asynchronously force all channels to IDLE, all counters to 0, interrupt=0, irq_any=0, fired_cnt=0, budget=BUDGET_INIT, and budget_empty=(BUDGET_INIT==0).
REQ-025 SHALL abandon any in-flight delay or assertion when reset asserts mid-operation; it SHALL resume from IDLE on the first clk edge after release.

Structure
REQ-026 SHALL place the FSM state enum, the ACK address stride (4), and the mode encodings in the shared package int_stim_pkg.
REQ-027 SHALL implement one channel (FSM plus delay and pulse counters) as sub-module int_stim_chan, instantiated NUM_CH times by a generate loop; budget arbitration and fired_cnt SHALL reside in the top level.

Verification
REQ-028 Verification SHALL cover: reset release, ch0 trig=0x3010, delay=3, PC reaches 0x3010 -> interrupt[0] rises 4 cycles later; store byteen=4'b0001 to 0x7f20 -> interrupt[0] low next cycle; fired_cnt=1.
REQ-029 Verification SHALL cover: PC held at trigger for 20 cycles with acks -> only one interrupt until PC leaves and returns.
REQ-030 Verification SHALL cover: BUDGET_INIT=1, ch1 and ch3 match in the same cycle -> only interrupt[1] rises, budget_empty=1, and further matches are ignored.
REQ-031 Verification SHALL cover: PULSE_MODE=1, PULSE_LEN=4 -> interrupt exactly 4 cycles high; an ack at 0x7f20 mid-pulse has no effect.
REQ-032 Verification SHALL cover: reset asserted while in WAIT_DLY with counter=2 -> interrupt stays 0, and budget and fired_cnt restore to their reset values.
REQ-033 Verification SHALL cover: ack to 0x7f24 while ch0 is asserted -> ch0 stays high; ack to 0x7f23 (byte of 0x7f20) -> ch0 clears.
